clamp_sat_pipe: RTL
===================

Name: clamp_sat_pipe

Overview:
- Multi-channel, pipelined successor to the single-value positive clamp used in the GPU colour path.
- Clamps NCH signed INW-bit lanes to an OUTW-bit range:
  - unsigned mode: 0..2^OUTW-1
  - signed mode: -2^(OUTW-1)..2^(OUTW-1)-1
- Per-lane clamp flags ride along with the data. Sticky flags and a saturation-beat counter accumulate for debug and status.
- Sits between the interpolator/blend stage and the pixel writer. Uses a valid/ready handshake with a skid buffer so back-pressure never drops a beat.

Parameters:
- NCH, 3, number of lanes (R,G,B default)
- INW, 16, signed input width per lane
- OUTW, 8, output width per lane
- SIGNED_OUT, 0, 0 = unsigned clamp range, 1 = two's-complement clamp range
- CNTW, 16, saturation counter width
- Legal configurations: unsigned requires INW >= OUTW+1; signed requires INW >= OUTW. Anything else is an elaboration error.

Ports:
- clk  in  1  clock
- i_nrst  in  1  synchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat
- i_value  in  NCH*INW  lane k at bits [k*INW +: INW], signed
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_value  out  NCH*OUTW  clamped lanes, same packing
- o_negClamp  out  NCH  per-lane low clamp occurred on this beat
- o_posClamp  out  NCH  per-lane high clamp occurred on this beat
- i_clrFlags  in  1  clear sticky flags and counter
- o_stickyNeg  out  NCH  accumulated low clamps
- o_stickyPos  out  NCH  accumulated high clamps
- o_satCount  out  CNTW  count of accepted beats with any clamp

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous, active-low on `i_nrst`.
- Reset values: all outputs 0 except o_ready=1. Skid buffer is emptied. Reset mid-transfer drops in-flight beats with no flush.
- Lane arithmetic, unsigned mode:
  - v<0 gives 0 and neg=1.
  - v>2^OUTW-1 gives all-ones and pos=1.
  - Otherwise v[OUTW-1:0].
- Lane arithmetic, signed mode:
  - v<-2^(OUTW-1) gives 100..0 and neg=1.
  - v>2^(OUTW-1)-1 gives 011..1 and pos=1.
  - Otherwise v[OUTW-1:0].
  - If INW==OUTW, pass through and flags are 0.
- Flag exclusivity: neg and pos are never both 1 for a lane.
- Input handshake: accept occurs when i_valid && o_ready. Clamp is computed combinationally from i_value and captured at the accept edge.
- Output stage (registered, latency 1 cycle):
  - Accepted beat appears on o_value/flags with o_valid=1 the cycle after accept.
  - Output holds stable while o_valid && !i_ready.
- Skid buffer (1 entry) and o_ready:
  - o_ready is registered: o_ready = !skid_full.
  - If output is stalled and a beat is accepted, the beat goes to the skid entry and o_ready drops next cycle.
  - When the output drains, skid data moves to the output stage and o_ready returns next cycle.
  - Full throughput: one beat per cycle with i_ready held high.
  - Ordering is preserved.
- Output states:
  - EMPTY to ONE on accept.
  - ONE to ONE on accept with drain, or no accept and no drain.
  - ONE to EMPTY on drain with no accept.
  - ONE to FULL on accept with no drain.
  - FULL to ONE on drain. No accept is possible in FULL.
- Sticky flags: updated at input accept. sticky |= lane flags.
- Saturation counter: +1 per accepted beat where any lane flag is set. Saturates at 2^CNTW-1 with no wrap.
- i_clrFlags: takes effect at the edge. A beat accepted in the same cycle is not lost:
  - sticky <= new beat flags
  - count <= (any flag ? 1 : 0)
- Flag timing: sticky/count outputs are registered and reflect beats accepted up to the previous edge.

Test Plan:
- Unsigned defaults, lanes {-5, 300, 128}, i_ready=1 -> next cycle o_value {0, 255, 128}; neg=001b, pos=010b (lane0=bit0); satCount=1; stickyNeg=001b, stickyPos=010b.
- Boundaries {255, 256, -1, 0} on NCH=4 -> {255, 255, 0, 0}; pos only on lane1, neg only on lane2.
- SIGNED_OUT=1, OUTW=8, lanes {-129, 127, 200} -> {-128 (0x80), 127, 127 (0x7F)}; neg=001b, pos=100b.
- Back-pressure: stream 0..9 at i_valid=1, i_ready low for cycles 3-6 -> o_ready low after one extra beat is accepted; no loss or duplication; output order 0..9; o_value stable while stalled.
- Counter/clear: CNTW=2, 5 clamping beats -> satCount stops at 3. Then i_clrFlags with a simultaneous clamping beat -> count=1, sticky = that beat's flags.
- Reset: assert i_nrst=0 with skid full -> next edge o_valid=0, o_ready=1, counts/sticky 0. First beat after release has latency 1.

Source files
------------

// File: rtl/clamp_sat_pipe.sv
// Multi-lane clamp to an OUTW-bit range (unsigned or two's complement) with
// per-lane clamp flags, a one-entry skid buffer, sticky flags and a saturation counter.
module clamp_sat_pipe #(
  parameter int NCH        = 3,
  parameter int INW        = 16,
  parameter int OUTW       = 8,
  parameter int SIGNED_OUT = 0,
  parameter int CNTW       = 16
) (
  input  logic                 clk,
  input  logic                 i_nrst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NCH*INW-1:0]   i_value,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NCH*OUTW-1:0]  o_value,
  output logic [NCH-1:0]       o_negClamp,
  output logic [NCH-1:0]       o_posClamp,
  input  logic                 i_clrFlags,
  output logic [NCH-1:0]       o_stickyNeg,
  output logic [NCH-1:0]       o_stickyPos,
  output logic [CNTW-1:0]      o_satCount
);

  generate
    if ((SIGNED_OUT == 0 && INW < OUTW + 1) || (SIGNED_OUT != 0 && INW < OUTW)) begin : g_bad_cfg
      $error("clamp_sat_pipe: INW is too narrow for OUTW in the selected clamp mode");
    end
  endgenerate

  localparam int HI_BITS = (SIGNED_OUT != 0) ? OUTW - 1 : OUTW;
  localparam int BW      = NCH * OUTW + 2 * NCH;

  // Limits are built bit by bit so that any INW/OUTW pair works, including INW == OUTW.
  function automatic logic [INW-1:0] hi_limit();
    logic [INW-1:0] r;
    r = '0;
    for (int b = 0; b < INW; b++) r[b] = (b < HI_BITS);
    return r;
  endfunction

  function automatic logic [INW-1:0] lo_limit();
    logic [INW-1:0] r;
    r = '0;
    for (int b = 0; b < INW; b++) r[b] = (SIGNED_OUT != 0) && (b >= OUTW - 1);
    return r;
  endfunction

  localparam logic [INW-1:0]  HI_LIM  = hi_limit();
  localparam logic [INW-1:0]  LO_LIM  = lo_limit();
  localparam logic [OUTW-1:0] HI_OUT  = HI_LIM[OUTW-1:0];
  localparam logic [OUTW-1:0] LO_OUT  = LO_LIM[OUTW-1:0];
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Combinational lane clamp on the incoming beat
  logic [NCH*OUTW-1:0] cl_value;
  logic [NCH-1:0]      cl_neg;
  logic [NCH-1:0]      cl_pos;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic signed [INW-1:0] v;
    assign v         = $signed(i_value[k*INW +: INW]);
    assign cl_neg[k] = v < $signed(LO_LIM);
    assign cl_pos[k] = v > $signed(HI_LIM);
    assign cl_value[k*OUTW +: OUTW] = cl_neg[k] ? LO_OUT :
                                      cl_pos[k] ? HI_OUT : v[OUTW-1:0];
  end

  logic [BW-1:0] cl_beat;
  assign cl_beat = {cl_pos, cl_neg, cl_value};

  // Handshake: a beat moves on a rising edge where valid && ready are both 1.
  // o_ready is registered and only drops when the skid entry is occupied.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        state_q;
  logic          out_valid_q;
  logic          ready_q;
  logic [BW-1:0] out_beat_q;
  logic [BW-1:0] skid_beat_q;

  logic accept;
  logic drain;
  assign accept = i_valid && ready_q;
  assign drain  = out_valid_q && i_ready;

  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      out_beat_q  <= '0;
      skid_beat_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_beat_q  <= cl_beat;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_beat_q <= cl_beat;
          end else if (accept) begin
            skid_beat_q <= cl_beat;
            ready_q     <= 1'b0;
            state_q     <= ST_FULL;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            out_beat_q <= skid_beat_q;
            ready_q    <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = out_valid_q;
  assign o_value    = out_beat_q[NCH*OUTW-1:0];
  assign o_negClamp = out_beat_q[NCH*OUTW +: NCH];
  assign o_posClamp = out_beat_q[NCH*OUTW+NCH +: NCH];

  // Status: a clear on the same edge as an accept keeps that beat's contribution.
  logic [NCH-1:0]  sticky_neg_q, sticky_neg_d;
  logic [NCH-1:0]  sticky_pos_q, sticky_pos_d;
  logic [CNTW-1:0] sat_cnt_q, sat_cnt_d;
  logic            sat_hit;

  assign sat_hit = accept && (|(cl_neg | cl_pos));

  always_comb begin
    sticky_neg_d = sticky_neg_q;
    sticky_pos_d = sticky_pos_q;
    sat_cnt_d    = sat_cnt_q;
    if (i_clrFlags) begin
      sticky_neg_d = accept ? cl_neg : '0;
      sticky_pos_d = accept ? cl_pos : '0;
      sat_cnt_d    = sat_hit ? CNTW'(1) : '0;
    end else begin
      if (accept) begin
        sticky_neg_d = sticky_neg_q | cl_neg;
        sticky_pos_d = sticky_pos_q | cl_pos;
      end
      if (sat_hit && (sat_cnt_q != CNT_MAX)) begin
        sat_cnt_d = sat_cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      sticky_neg_q <= '0;
      sticky_pos_q <= '0;
      sat_cnt_q    <= '0;
    end else begin
      sticky_neg_q <= sticky_neg_d;
      sticky_pos_q <= sticky_pos_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign o_stickyNeg = sticky_neg_q;
  assign o_stickyPos = sticky_pos_q;
  assign o_satCount  = sat_cnt_q;

endmodule
